// File: rtl/m_dm_ctrl_pkg.sv
// Shared constants for the M-stage data memory controller: array geometry,
// FSM state encoding, byte-enable patterns and byte-enable selectors.
package m_dm_ctrl_pkg;

  localparam int unsigned DM_DEPTH_LOG2 = 12;
  localparam logic [31:0] DM_BASE_ADDR  = 32'h0000_0000;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } dm_state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Full-word store.
  function automatic logic be_w(input logic [3:0] be);
    return be == BE_WORD;
  endfunction

  // Halfword store in either half.
  function automatic logic be_h(input logic [3:0] be);
    return (be == BE_HALF_LO) || (be == BE_HALF_HI);
  endfunction

  // Single-byte store.
  function automatic logic be_b(input logic [3:0] be);
    return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000);
  endfunction

endpackage

// File: rtl/m_dm_ctrl_merge.sv
// Byte-masked merge of store data into an existing word.
// Ports: old_word (current word), wdata (lane-aligned store data),
//        byteen (per-byte enable), merged (resulting word).
module m_dm_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/m_dm_ctrl.sv
// M-stage data memory controller: zero-sweeps the word array after reset
// (stalling the pipeline meanwhile), then performs byte-masked stores,
// asynchronous word loads, access-fault detection and a registered store trace.
// Ports: clk, reset_n (async active-low); dwa/dwd/byteen/we/re/pc from M;
//        drd (raw load word), stall, addr_err; trace_valid/pc/addr/data.
module m_dm_ctrl
  import m_dm_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DM_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = DM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dwa,
  input  logic [31:0] dwd,
  input  logic [3:0]  byteen,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] pc,
  output logic [31:0] drd,
  output logic        stall,
  output logic        addr_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  dm_state_e             state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_idx, clr_idx_nxt;

  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic [31:0]           merged;
  logic                  run;
  logic                  commit;

  // Address decode relative to the array base.
  assign off      = dwa - BASE_ADDR;
  assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign rd_word  = mem[idx];
  assign run      = (state == S_RUN);
  assign stall    = ~run;

  // Access fault: range, store alignment per width, empty store, word-load alignment.
  always_comb begin
    addr_err = 1'b0;
    if (run && (we || re)) begin
      if (!in_range)                               addr_err = 1'b1;
      if (we && be_w(byteen) && (dwa[1:0] != 2'b00)) addr_err = 1'b1;
      if (we && be_h(byteen) && dwa[0])            addr_err = 1'b1;
      if (we && (byteen == 4'b0000))               addr_err = 1'b1;
      if (re && (dwa[1:0] != 2'b00))               addr_err = 1'b1;
    end
  end

  assign drd    = (run && in_range) ? rd_word : 32'h0;
  assign commit = run & we & ~addr_err;

  m_dm_merge u_merge (
    .old_word (rd_word),
    .wdata    (dwd),
    .byteen   (byteen),
    .merged   (merged)
  );

  // Sweep sequencing: one word per cycle, leave S_CLEAR after the last index.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    if (state == S_CLEAR) begin
      clr_idx_nxt = clr_idx + DEPTH_LOG2'(1);
      if (clr_idx == {DEPTH_LOG2{1'b1}}) state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Array write port: zero sweep or committed store.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_idx] <= 32'h0;
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

  // Store trace; payload holds between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid <= 1'b0;
      trace_pc    <= 32'h0;
      trace_addr  <= 32'h0;
      trace_data  <= 32'h0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_pc   <= pc;
        trace_addr <= {dwa[31:2], 2'b00};
        trace_data <= merged;
      end
    end
  end

endmodule
